pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Drives the stall (`en`, high = advance) and flush (`*_flush_n`, active-low, synchronous at the consumer) controls of the F/D, D/E, E/M and M/W pipeline registers.
- Consumes hazard information from the decode, execute, memory and writeback stages, plus the data-cache miss/refill handshake.
- Produces ALU forwarding selects.
- Contains a miss-freeze FSM, a refill watchdog and stall/miss performance counters.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- SRC_WIDTH, 2, ResultSrc width.
- LOAD_SRC, 2'b01, ResultSrc encoding that marks a load in E.
- CNT_WIDTH, 32, performance counter width.
- MISS_TIMEOUT, 255, maximum cycles in MISS before the error flag is set.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- Rs1_d  in  REG_ADDR_WIDTH  source register 1 in D.
- Rs2_d  in  REG_ADDR_WIDTH  source register 2 in D.
- Rs1_e  in  REG_ADDR_WIDTH  source register 1 in E.
- Rs2_e  in  REG_ADDR_WIDTH  source register 2 in E.
- Rd_e  in  REG_ADDR_WIDTH  destination register in E.
- RegWrite_e  in  1  E writes the register file.
- ResultSrc_e  in  SRC_WIDTH  E result source.
- PCSrc_e  in  1  taken branch or jump resolved in E.
- Rd_m  in  REG_ADDR_WIDTH  destination register in M.
- RegWrite_m  in  1  M writes the register file.
- Rd_w  in  REG_ADDR_WIDTH  destination register in W.
- RegWrite_w  in  1  W writes the register file.
- mem_req_m  in  1  M issues a data-cache access this cycle.
- cache_miss_m  in  1  data cache reports a miss for mem_req_m.
- refill_done  in  1  one-cycle pulse: refill complete.
- en_f, en_d, en_e, en_m  out  1 each  advance enables for the PC/F-D, D-E, E-M and M-W registers.
- flush_d_n, flush_e_n  out  1 each  active-low flushes for the F-D and D-E registers.
- ForwardA_e, ForwardB_e  out  2 each  forwarding select: 00 = register file, 01 = W result, 10 = M ALU result.
- miss_busy  out  1  FSM not in RUN.
- timeout_err  out  1  sticky refill-timeout flag.
- stall_cycles  out  CNT_WIDTH  count of cycles with en_d == 0.
- miss_count  out  CNT_WIDTH  count of RUN->MISS transitions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = RUN; timer, counters and timeout_err = 0.
  - Outputs held at: en_* = 1, flush_d_n = flush_e_n = 0 (pipeline cleared), Forward* = 00, miss_busy = 0.
  - Release is synchronous to clk.
- FSM states:
  - RUN -> MISS when mem_req_m & cache_miss_m.
  - MISS -> REPLAY when refill_done.
  - REPLAY -> RUN after exactly 1 cycle.
  - Unused encodings -> RUN.
- MISS and REPLAY:
  - en_f = en_d = en_e = en_m = 0.
  - flush_d_n = flush_e_n = 1. Flush must never be asserted during a freeze, because it overrides en at the consumer.
  - miss_busy = 1.
  - PCSrc_e and load-use conditions are ignored.
- The entry cycle into MISS is itself frozen: the combinational output uses `next_freeze = (state != RUN) | (mem_req_m & cache_miss_m)`.
- RUN, priority 1, branch (PCSrc_e): flush_d_n = 0, flush_e_n = 0, all en = 1.
- RUN, priority 2, load-use:
  - Condition: ResultSrc_e == LOAD_SRC & RegWrite_e & Rd_e != 0 & (Rd_e == Rs1_d | Rd_e == Rs2_d).
  - Response: en_f = en_d = 0, flush_e_n = 0, en_e = en_m = 1, flush_d_n = 1.
- RUN otherwise: all en = 1, flushes deasserted.
- Forwarding (combinational, every state), shown for A; B is identical using Rs2_e:
  - 10 if RegWrite_m & Rd_m != 0 & Rd_m == Rs1_e;
  - else 01 if RegWrite_w & Rd_w != 0 & Rd_w == Rs1_e;
  - else 00.
  - M has priority over W. x0 never forwards.
- Timer:
  - Clears on MISS entry and increments each cycle in MISS.
  - At count == MISS_TIMEOUT, timeout_err sets. It is sticky until reset.
  - The FSM keeps waiting for refill_done.
- refill_done arriving in the same cycle as MISS entry is ignored (no refill pending yet); it is not counted or latched.
- Counters:
  - stall_cycles increments on each posedge where en_d was 0, outside reset.
  - miss_count increments on each RUN->MISS transition.
  - Both wrap at 2^CNT_WIDTH.
- Reset mid-MISS: state returns to RUN immediately; timer, counters and timeout_err clear.

Test Plan:
- Load x5 in E (ResultSrc_e = 01, Rd_e = 5), Rs1_d = 5 -> exactly 1 cycle of en_f = en_d = 0, flush_e_n = 0, en_e = en_m = 1; stall_cycles = 1.
- Same load with Rd_e = 0, Rs1_d = 0 -> no stall; all en = 1.
- PCSrc_e = 1 while a load-use condition also holds -> flush_d_n = flush_e_n = 0, en_f = en_d = 1 (branch wins).
- Forwarding: Rd_m = Rd_w = 7, both RegWrite = 1, Rs1_e = 7, Rs2_e = 7 -> ForwardA_e = ForwardB_e = 10. With RegWrite_m = 0 -> both 01.
- Miss with refill_done 6 cycles later:
  - All en = 0 for 8 cycles in total (entry cycle + 6 MISS + 1 REPLAY).
  - Flushes stay 1 throughout, even with PCSrc_e = 1 during the freeze.
  - miss_count = 1, stall_cycles = 8.
- Miss with no refill for 256 cycles -> timeout_err = 1 at the 256th MISS cycle. Then assert rst_n = 0 mid-MISS -> state RUN, timeout_err = 0, counters 0, flush_d_n = flush_e_n = 0 while reset is held.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Stall / flush / forwarding control for a 5-stage in-order pipeline, with a
// data-cache miss freeze, a refill watchdog and two performance counters.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   Rs1_d, Rs2_d               source registers of the instruction in D
//   Rs1_e, Rs2_e, Rd_e         source/destination registers in E
//   RegWrite_e, ResultSrc_e    E writes the register file / E result source
//   PCSrc_e                    taken branch or jump resolved in E
//   Rd_m, RegWrite_m           destination / write enable in M
//   Rd_w, RegWrite_w           destination / write enable in W
//   mem_req_m, cache_miss_m    data-cache access in M and its miss indication
//   refill_done                one-cycle pulse: refill complete
//   en_f, en_d, en_e, en_m     advance enables for PC/F-D, D-E, E-M, M-W regs
//   flush_d_n, flush_e_n       active-low flushes for F-D and D-E registers
//   ForwardA_e, ForwardB_e     00 = register file, 01 = W result, 10 = M ALU
//   miss_busy                  miss FSM is not in RUN
//   timeout_err                sticky refill-timeout flag
//   stall_cycles               cycles with en_d low
//   miss_count                 RUN -> MISS transitions
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned                 REG_ADDR_WIDTH = 5,
    parameter int unsigned                 SRC_WIDTH      = 2,
    parameter logic [SRC_WIDTH-1:0]        LOAD_SRC       = 2'b01,
    parameter int unsigned                 CNT_WIDTH      = 32,
    parameter int unsigned                 MISS_TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1_e,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2_e,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_e,
    input  logic                      RegWrite_e,
    input  logic [SRC_WIDTH-1:0]      ResultSrc_e,
    input  logic                      PCSrc_e,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_m,
    input  logic                      RegWrite_m,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_w,
    input  logic                      RegWrite_w,
    input  logic                      mem_req_m,
    input  logic                      cache_miss_m,
    input  logic                      refill_done,
    output logic                      en_f,
    output logic                      en_d,
    output logic                      en_e,
    output logic                      en_m,
    output logic                      flush_d_n,
    output logic                      flush_e_n,
    output logic [1:0]                ForwardA_e,
    output logic [1:0]                ForwardB_e,
    output logic                      miss_busy,
    output logic                      timeout_err,
    output logic [CNT_WIDTH-1:0]      stall_cycles,
    output logic [CNT_WIDTH-1:0]      miss_count
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_MISS   = 2'b01;
    localparam logic [1:0] ST_REPLAY = 2'b10;

    localparam int unsigned           TMR_W   = (MISS_TIMEOUT < 2) ? 1 : $clog2(MISS_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]      TMR_MAX = TMR_W'(MISS_TIMEOUT);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [TMR_W-1:0] timer;
    logic             miss_start;
    logic             next_freeze;
    logic             load_use;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (RegWrite_m && (Rd_m != '0) && (Rd_m == rs))
            sel = 2'b10;
        else if (RegWrite_w && (Rd_w != '0) && (Rd_w == rs))
            sel = 2'b01;
        return sel;
    endfunction

    assign miss_start  = (state == ST_RUN) && mem_req_m && cache_miss_m;
    // The cycle that detects the miss is frozen too, before state reaches MISS.
    assign next_freeze = (state != ST_RUN) || (mem_req_m && cache_miss_m);
    assign load_use    = (ResultSrc_e == LOAD_SRC) && RegWrite_e && (Rd_e != '0) &&
                         ((Rd_e == Rs1_d) || (Rd_e == Rs2_d));

    always_comb begin
        state_nxt = ST_RUN;
        case (state)
            ST_RUN:    state_nxt = miss_start ? ST_MISS : ST_RUN;
            ST_MISS:   state_nxt = refill_done ? ST_REPLAY : ST_MISS;
            ST_REPLAY: state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        en_f       = 1'b1;
        en_d       = 1'b1;
        en_e       = 1'b1;
        en_m       = 1'b1;
        flush_d_n  = 1'b1;
        flush_e_n  = 1'b1;
        ForwardA_e = 2'b00;
        ForwardB_e = 2'b00;
        miss_busy  = 1'b0;
        if (!rst_n) begin
            // Hold the pipeline cleared while reset is asserted.
            flush_d_n = 1'b0;
            flush_e_n = 1'b0;
        end else begin
            ForwardA_e = fwd_sel(Rs1_e);
            ForwardB_e = fwd_sel(Rs2_e);
            miss_busy  = (state != ST_RUN);
            if (next_freeze) begin
                // Flush overrides en at the consumer, so it stays off while frozen.
                en_f = 1'b0;
                en_d = 1'b0;
                en_e = 1'b0;
                en_m = 1'b0;
            end else if (PCSrc_e) begin
                flush_d_n = 1'b0;
                flush_e_n = 1'b0;
            end else if (load_use) begin
                en_f      = 1'b0;
                en_d      = 1'b0;
                flush_e_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            timer        <= '0;
            timeout_err  <= 1'b0;
            stall_cycles <= '0;
            miss_count   <= '0;
        end else begin
            state <= state_nxt;
            if (!en_d)
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (miss_start) begin
                miss_count <= miss_count + CNT_WIDTH'(1);
                timer      <= '0;
            end else if (state == ST_MISS) begin
                if (timer != TMR_MAX)
                    timer <= timer + TMR_W'(1);
                // Raised on the edge that makes the timer reach the limit.
                if (timer >= TMR_MAX - TMR_W'(1))
                    timeout_err <= 1'b1;
            end
        end
    end

endmodule
